// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmitter slice.
package i2s_pkg;

  localparam int SAMPLE_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } tx_state_t;

  typedef logic signed [23:0] sample_t;

  // lrclk level that marks the left channel slot
  localparam logic LEFT_SLOT = 1'b1;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample bus, frame clock and status flags between the effect chain and the
// I2S transmitter. The chain side is master, the transmitter is slave.
interface i2s_transmitter_if #(
  parameter int SAMPLE_W = 24
);
  logic                       lrclk;
  logic signed [SAMPLE_W-1:0] ldata;
  logic signed [SAMPLE_W-1:0] rdata;
  logic                       dvalid;
  logic                       sdout;
  logic                       underrun;
  logic                       overrun;

  modport master (
    output lrclk, ldata, rdata, dvalid,
    input  sdout, underrun, overrun
  );

  modport slave (
    input  lrclk, ldata, rdata, dvalid,
    output sdout, underrun, overrun
  );
endinterface

// File: rtl/i2s_tx_sample_buf.sv
// Pending/active double buffer for the I2S transmitter.
// Build option: I2S_TX_UNDERRUN_HOLD_EN -- on underrun the active pair is
// kept (last pair repeats); without it the active pair is cleared (silence).
module i2s_tx_sample_buf
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                capture,     // dvalid rising edge this cycle
  input  logic                left_start,  // left frame begins this cycle
  input  logic [SAMPLE_W-1:0] ldata,
  input  logic [SAMPLE_W-1:0] rdata,
  output logic [SAMPLE_W-1:0] load_l,      // left word the shifter loads now
  output logic [SAMPLE_W-1:0] act_r,       // right word of the active pair
  output logic                underrun,
  output logic                overrun
);

  logic [SAMPLE_W-1:0] pend_l, pend_r, act_l;
  logic                pend_v;
  logic [SAMPLE_W-1:0] act_l_nxt, act_r_nxt;

  // Next active pair: transfer pending pair at left start, else hold/clear
  always_comb begin
    // NOTE: every output gets a default first so no latch can be inferred.
    act_l_nxt = act_l;
    act_r_nxt = act_r;
    if (left_start) begin
      if (pend_v) begin
        act_l_nxt = pend_l;
        act_r_nxt = pend_r;
      end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        act_l_nxt = act_l;
        act_r_nxt = act_r;
`else
        act_l_nxt = '0;
        act_r_nxt = '0;
`endif
      end
    end
  end

  assign load_l = act_l_nxt;

  // Pending slot: newest captured pair wins; consumed by a left start
  always_ff @(posedge sclk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      pend_l <= '0;
      pend_r <= '0;
      pend_v <= 1'b0;
    end else begin
      if (capture) begin
        pend_l <= ldata;
        pend_r <= rdata;
      end
      pend_v <= capture | (pend_v & ~left_start);
    end
  end

  // Active pair register feeding the shifter
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      act_l <= '0;
      act_r <= '0;
    end else begin
      act_l <= act_l_nxt;
      act_r <= act_r_nxt;
    end
  end

  // One-cycle status pulses, raised on the edge of the causing event
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      underrun <= left_start & ~pend_v;
      // a pending pair consumed by a simultaneous left start is not lost
      overrun  <= capture & pend_v & ~left_start;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: captures stereo pairs on dvalid rising edges and shifts
// them MSB-first on sdout with the standard one-bit delay after lrclk edges.
// Build option: I2S_TX_UNDERRUN_HOLD_EN (see i2s_tx_sample_buf).
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
  input  logic               sclk,
  input  logic               rst,
  i2s_transmitter_if.slave   bus
);

  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_W - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_PAD   = PAD;

  logic                dv_prev, prev_lr;
  logic                capture, lr_edge, left_start;
  logic [1:0]          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] load_l, act_r;
  logic                sdout_q;

  assign capture    = bus.dvalid & ~dv_prev;
  assign lr_edge    = prev_lr ^ bus.lrclk;
  assign left_start = lr_edge & (bus.lrclk == LEFT_SLOT);

  // Edge detectors; prev_lr follows lrclk in reset so release is edge-free
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      dv_prev <= 1'b0;
      prev_lr <= bus.lrclk;
    end else begin
      dv_prev <= bus.dvalid;
      prev_lr <= bus.lrclk;
    end
  end

  i2s_tx_sample_buf #(
    .SAMPLE_W (SAMPLE_W)
  ) u_buf (
    .sclk       (sclk),
    .rst        (rst),
    .capture    (capture),
    .left_start (left_start),
    .ldata      (bus.ldata),
    .rdata      (bus.rdata),
    .load_l     (load_l),
    .act_r      (act_r),
    .underrun   (bus.underrun),
    .overrun    (bus.overrun)
  );

  // Slot FSM: any lrclk edge reloads the shifter, short slots drop LSBs
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (lr_edge) begin
      state   <= ST_SHIFT;
      bit_cnt <= CNT_LAST;
      shreg   <= (bus.lrclk == LEFT_SLOT) ? load_l : act_r;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (bit_cnt == '0) begin
            state <= ST_PAD;
            shreg <= '0;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            shreg   <= {shreg[SAMPLE_W-2:0], 1'b0};
          end
        end
        ST_PAD:  shreg <= '0;
        ST_IDLE: shreg <= '0;
        default: begin
          state <= ST_IDLE;
          shreg <= '0;
        end
      endcase
    end
  end

  // Launch flop on the falling edge gives the DAC a full half-cycle of setup
  always_ff @(negedge sclk or posedge rst) begin
    if (rst) sdout_q <= 1'b0;
    else     sdout_q <= shreg[SAMPLE_W-1];
  end

  assign bus.sdout = sdout_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: a reference model pushes expected
// 32-bit slot words when each frame edge is seen; a collector assembles the
// serial bits and pops/compares. Honours I2S_TX_UNDERRUN_HOLD_EN.
module tb_i2s_transmitter;

  localparam int SW = 24;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   pos  = 0;

  i2s_transmitter_if #(.SAMPLE_W(SW)) bus ();

  i2s_transmitter #(.SAMPLE_W(SW)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // frame generator: 32 sclk left (lrclk=1), 32 right, changing on falling edge
  initial begin
    bus.lrclk  = 1'b1;
    bus.ldata  = '0;
    bus.rdata  = '0;
    bus.dvalid = 1'b0;
    forever begin
      @(negedge sclk);
      pos = (pos + 1) % 64;
      bus.lrclk = (pos < 32);
    end
  end

  // reference model + scoreboard state
  logic [SW-1:0] m_pl, m_pr, m_al, m_ar;
  logic          m_pv, m_dv, m_prev_lr;
  logic          exp_ur = 1'b0, exp_or = 1'b0;
  logic [31:0]   sb_q[$];
  logic [31:0]   col_word, last_left, last_right, exp_w;
  int            col_cnt;
  bit            col_active = 1'b0, col_left;
  int            left_done = 0, right_done = 0;
  int            ur_cnt = 0, or_cnt = 0;

  always @(posedge sclk) begin
    logic cap, le, re;
    if (rst) begin
      m_prev_lr  = bus.lrclk;
      m_dv = 1'b0; m_pv = 1'b0;
      m_pl = '0; m_pr = '0; m_al = '0; m_ar = '0;
      exp_ur = 1'b0; exp_or = 1'b0;
      col_active = 1'b0;
      sb_q.delete();
    end else begin
      cap = bus.dvalid && !m_dv;
      le  = bus.lrclk && !m_prev_lr;
      re  = !bus.lrclk && m_prev_lr;
      exp_ur = le && !m_pv;
      exp_or = cap && m_pv && !le;
      // collect the bit launched on the previous falling edge
      if (col_active) begin
        col_word = {col_word[30:0], bus.sdout};
        col_cnt++;
        if (col_cnt == 32) begin
          col_active = 1'b0;
          if (sb_q.size() == 0) begin
            check("sb_size", sb_q.size(), 1);
          end else begin
            exp_w = sb_q.pop_front();
            check(col_left ? "slot_left" : "slot_right", col_word, exp_w);
          end
          if (col_left) begin left_done++;  last_left  = col_word; end
          else          begin right_done++; last_right = col_word; end
        end
      end
      if (le) begin
        if (m_pv) begin
          m_al = m_pl; m_ar = m_pr;
        end else begin
`ifndef I2S_TX_UNDERRUN_HOLD_EN
          m_al = '0; m_ar = '0;
`endif
        end
        sb_q.push_back({m_al, 8'h00});
      end
      if (re) sb_q.push_back({m_ar, 8'h00});
      if (le || re) begin
        col_active = 1'b1;
        col_cnt    = 0;
        col_left   = le;
        col_word   = '0;
      end
      if (le && m_pv) m_pv = 1'b0;
      if (cap) begin
        m_pl = bus.ldata; m_pr = bus.rdata; m_pv = 1'b1;
      end
      m_prev_lr = bus.lrclk;
      m_dv      = bus.dvalid;
    end
  end

  // flag checks away from the active edge
  always @(negedge sclk) begin
    check("underrun", bus.underrun, rst ? 1'b0 : exp_ur);
    check("overrun",  bus.overrun,  rst ? 1'b0 : exp_or);
    if (bus.underrun) ur_cnt++;
    if (bus.overrun)  or_cnt++;
  end

  task automatic wait_pos(input int p);
    int guard = 0;
    do begin
      @(posedge sclk);
      guard++;
    end while (pos != p && guard < 200);
    if (guard >= 200) check("wait_pos_timeout", guard, 0);
  endtask

  // the pair is captured on the posedge where pos == at_pos
  task automatic drive_pair(input logic [SW-1:0] l, input logic [SW-1:0] r, input int at_pos);
    wait_pos((at_pos + 63) % 64);
    #2;
    bus.ldata  = l;
    bus.rdata  = r;
    bus.dvalid = 1'b1;
    repeat (2) @(posedge sclk);
    #2 bus.dvalid = 1'b0;
  endtask

  task automatic wait_slot(input bit left, output logic [31:0] w);
    int start = left ? left_done : right_done;
    int guard = 0;
    do begin
      @(posedge sclk);
      #1;
      guard++;
    end while ((left ? left_done : right_done) == start && guard < 200);
    if (guard >= 200) check("slot_timeout", guard, 0);
    w = left ? last_left : last_right;
  endtask

  initial begin
    logic [31:0] w;
    int ur0, or0;

    // reset state
    #23;
    check("rst_sdout",    bus.sdout,    1'b0);
    check("rst_underrun", bus.underrun, 1'b0);
    check("rst_overrun",  bus.overrun,  1'b0);

    // basic pair, MSB-first with zero pad
    wait_pos(40);
    #2 rst = 1'b0;
    ur0 = ur_cnt;
    drive_pair(24'h800001, 24'h7FFFFE, 45);
    wait_slot(1'b1, w);
    check("t1_left", w, 32'h8000_0100);
    check("t1_ur", ur_cnt - ur0, 0);
    wait_slot(1'b0, w);
    check("t1_right", w, 32'h7FFF_FE00);

    // no data after reset: underrun every left start, silence
    #1 rst = 1'b1;
    wait_pos(40);
    #2 rst = 1'b0;
    ur0 = ur_cnt;
    wait_slot(1'b1, w);
    check("t2_left0", w, 32'h0);
    wait_slot(1'b1, w);
    check("t2_left1", w, 32'h0);
    check("t2_ur", ur_cnt - ur0, 2);

    // single pair then starvation
    drive_pair(24'h123456, 24'h654321, 40);
    wait_slot(1'b1, w);
    check("t3_left", w, 32'h1234_5600);
    ur0 = ur_cnt;
    wait_slot(1'b1, w);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    check("t3_repeat", w, 32'h1234_5600);
`else
    check("t3_silence", w, 32'h0);
`endif
    check("t3_ur", ur_cnt - ur0, 1);

    // two captures in one frame: newest wins, one overrun
    or0 = or_cnt;
    drive_pair(24'h111111, 24'h111111, 36);
    drive_pair(24'h222222, 24'h222222, 50);
    wait_slot(1'b1, w);
    check("t4_left", w, 32'h2222_2200);
    check("t4_or", or_cnt - or0, 1);

    // capture coincident with left start while a pair is pending
    or0 = or_cnt;
    drive_pair(24'hAAAAAA, 24'hAAAAAA, 50);
    drive_pair(24'h555555, 24'h555555, 0);
    wait_slot(1'b1, w);
    check("t5_left_old", w, 32'hAAAA_AA00);
    wait_slot(1'b1, w);
    check("t5_left_new", w, 32'h5555_5500);
    check("t5_or", or_cnt - or0, 0);

    // reset in the middle of a left slot
    drive_pair(24'hFFFFFF, 24'hFFFFFF, 40);
    wait_pos(11);
    #2 check("t6_pre_rst", bus.sdout, 1'b1);
    rst = 1'b1;
    #1 check("t6_rst_sdout", bus.sdout, 1'b0);
    repeat (3) @(posedge sclk);
    #2 rst = 1'b0;
    for (int i = 0; i < 40 && pos != 32; i++) begin
      @(posedge sclk);
      #1 check("t6_quiet", bus.sdout, 1'b0);
    end
    wait_slot(1'b0, w);
    check("t6_first_right", w, 32'h0);
    wait_slot(1'b1, w);
    check("t6_next_left", w, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serialises processed stereo samples onto the DAC's I2S data line. Sits at the end of the pedal chain, downstream of the receiver and effect stages. It consumes parallel `ldata`/`rdata` words qualified by `dvalid` and shifts them out MSB-first on `sdout`, framed by the shared `lrclk`. A two-level sample buffer decouples the effect pipeline from frame timing and reports underrun and overrun.

## Interface
- `SAMPLE_W`, 24, bits per sample and per data slot; must be ≤ 31.
- `rst`  input  1  reset, asynchronous, active-high.
- `sclk`  input  1  serial bit clock; all logic on posedge except the `sdout` launch flop.
- `lrclk`  input  1  word select, shared with the receiver; 1 = left slot, 0 = right slot. Changes on sclk falling edge.
- `ldata`  input  SAMPLE_W  signed left sample.
- `rdata`  input  SAMPLE_W  signed right sample.
- `dvalid`  input  1  sample-pair valid; the pair is captured on its 0→1 transition.
- `sdout`  output  1  serial data to the DAC.
- `underrun`  output  1  one-sclk pulse: left frame started with no new pair buffered.
- `overrun`  output  1  one-sclk pulse: new pair arrived while the previous one was still pending.

## Operation
- Input capture:
  - `dv_prev` registers `dvalid`. A rising edge (`dvalid & ~dv_prev`) writes `ldata`/`rdata` into `pend_l`/`pend_r` and sets `pend_v`.
  - If `pend_v` was already 1, the pending pair is overwritten with the newest pair and `overrun` pulses.
- Frame detection: `prev_lr` registers `lrclk`. An edge is `prev_lr ^ lrclk`, sampled at posedge sclk.
- Left-frame start (edge with `lrclk` = 1):
  - If `pend_v` (value before this clock) is 1: `act_l`/`act_r` ← `pend_l`/`pend_r`, and `pend_v` clears unless a capture occurs in the same cycle.
  - If `pend_v` is 0: `underrun` pulses and the active pair is handled per Configuration.
  - The shift register loads the new `act_l`.
- Right-frame start (edge with `lrclk` = 0): the shift register loads `act_r`. No buffer transfer occurs.
- Simultaneous capture and left-frame start:
  - The transfer uses the old pending pair.
  - The new pair becomes pending with `pend_v` = 1.
  - No overrun is flagged unless `pend_v` was 1 and the transfer did not consume it.
- FSM states:
  - IDLE: wait for an edge → LOAD action, then SHIFT.
  - SHIFT: shift left one bit per clock; bit counter counts SAMPLE_W−1 down to 0; at 0 → PAD.
  - PAD: shift register zero, `sdout` 0; stay until the next edge.
  - An edge in any state restarts as above; a short frame truncates the LSBs.
- Width: samples pass through unmodified, two's complement, MSB first. Slot bits beyond SAMPLE_W are 0.

## Timing
- Reset values:
  - `sdout`, `underrun`, `overrun` = 0.
  - `prev_lr` ← `lrclk`, so no spurious edge after release.
  - `dv_prev` = 0, `pend_v` = 0; all data registers 0; state IDLE; counter 0.
- Serial timing: edge detected at posedge k → `sdout` shows bit SAMPLE_W−1 from negedge k (the standard I2S one-bit delay relative to `lrclk`). Bit SAMPLE_W−1−i appears at negedge k+i.
- Pipeline latency: capture to first serial bit is at most one full stereo frame plus one sclk.
- Flags: `underrun` and `overrun` assert in the same posedge as the causing event, for exactly one cycle.
- Reset mid-frame: all state clears immediately and `sdout` drops to 0. The first edge after release starts a fresh slot; if that slot is right, it sends zero.

## Configuration
- `I2S_TX_UNDERRUN_HOLD_EN` defined: on underrun, `act_l`/`act_r` keep their previous values, so the last pair repeats.
- Undefined: on underrun, `act_l`/`act_r` are cleared, so silence is sent.
- The `underrun` pulse behaves identically in both builds.

## Structure
- Package `i2s_pkg`:
  - `SAMPLE_W_DEFAULT` = 24.
  - `tx_state_t` enum {IDLE, SHIFT, PAD}.
  - `sample_t` typedef (logic signed [23:0]).
  - `LEFT_SLOT` = 1'b1.
- Sub-module `i2s_tx_sample_buf` holds the pending/active double buffer:
  - capture, transfer, and the overrun/underrun logic;
  - underrun hold/clear under the macro.
- The top level keeps edge detection, the FSM, the counter, the shift register, and the negedge `sdout` flop.

## Test plan
- Reset, then one pair L=0x800001, R=0x7FFFFE, then a full frame (32 sclk per slot) → left slot bits 1000…0001, then 8 zeros; right slot 0111…1110; `underrun` = 0.
- No `dvalid` after reset, two frames → `underrun` pulses at each left-frame start; `sdout` stays 0 in both builds.
- Pair 0x123456 sent once, then no more → with the macro, 0x123456 repeats in the next frame; without it, zeros follow; `underrun` pulses.
- Two `dvalid` rises within one frame (0x111111, then 0x222222) → `overrun` pulses once; next left slot sends 0x222222.
- `dvalid` rise in the same cycle as a left edge, with `pend_v` = 1 (0xAAAAAA pending, 0x555555 new) → 0xAAAAAA sent now, 0x555555 in the next frame, no overrun.
- Assert `rst` at bit 10 of a left slot → `sdout` = 0 immediately. After release, no output until an `lrclk` edge; then the first slot sends zero.
